// File: rtl/nibble_serial_add_seq_if.sv
// Handshake and adder-core bus for nibble_serial_add_seq.
//   START/A/B     : requester -> sequencer (operands captured on accepted START)
//   BUSY/DONE/SUM : sequencer -> requester (SUM is WIDTH+1 bits, carry-out in MSB)
//   ADD_A/ADD_B   : sequencer -> external 4-bit carry-less adder core
//   ADD_SUM       : core -> sequencer, combinational ADD_A+ADD_B
// Modports: master (requester), slave (sequencer), core (adder).
interface nibble_serial_add_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic             START;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             BUSY;
  logic             DONE;
  logic [WIDTH:0]   SUM;
  logic [3:0]       ADD_A;
  logic [3:0]       ADD_B;
  logic [4:0]       ADD_SUM;

  modport master (
    output START, A, B,
    input  BUSY, DONE, SUM
  );

  modport slave (
    input  START, A, B, ADD_SUM,
    output BUSY, DONE, SUM, ADD_A, ADD_B
  );

  modport core (
    input  ADD_A, ADD_B,
    output ADD_SUM
  );
endinterface

// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq
// Adds two WIDTH-bit unsigned operands, least-significant nibble first, by
// time-sharing one external 4-bit adder core that has no carry-in. Each nibble
// uses an operand pass (A_nib+B_nib) followed by a carry-fold pass
// (partial+cin).
// Ports:
//   CLK   : clock, rising edge
//   RESET : synchronous, active-high
//   bus   : nibble_serial_add_seq_if.slave (START/A/B in, BUSY/DONE/SUM out,
//           ADD_A/ADD_B to the core, ADD_SUM from the core)
// Build option:
//   CARRY_SKIP_EN : when defined, a nibble entered with cin=0 is finished in
//                   the operand pass and the carry-fold pass is skipped.
//                   SUM is identical in both builds; only latency differs.
module nibble_serial_add_seq #(
  parameter int unsigned WIDTH = 16
) (
  input logic                    CLK,
  input logic                    RESET,
  nibble_serial_add_seq_if.slave bus
);

  localparam int unsigned NIB   = WIDTH / 4;
  localparam int unsigned IDX_W = (NIB > 1) ? $clog2(NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIB - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ADD,
    S_CARRY,
    S_DONE
  } state_t;

  state_t state;
  state_t state_next;

  logic [NIB-1:0][3:0] a_r;
  logic [NIB-1:0][3:0] b_r;
  logic [NIB-1:0][3:0] sum_nib;
  logic                cout;
  logic [IDX_W-1:0]    idx;
  logic                cin;
  logic [4:0]          t;
  logic                busy_r;
  logic                done_r;
  logic [3:0]          add_a;
  logic [3:0]          add_b;
  logic                last_nib;
  logic                accept;

  assign last_nib = (idx == LAST_IDX);
  assign accept   = (state == S_IDLE) && bus.START;

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state and core operand selection.
  always_comb begin
    state_next = state;
    add_a      = '0;
    add_b      = '0;
    unique case (state)
      S_IDLE: begin
        if (bus.START) begin
          state_next = S_ADD;
        end
      end
      S_ADD: begin
        add_a = a_r[idx];
        add_b = b_r[idx];
`ifdef CARRY_SKIP_EN
        if (!cin) begin
          state_next = last_nib ? S_DONE : S_ADD;
        end else begin
          state_next = S_CARRY;
        end
`else
        state_next = S_CARRY;
`endif
      end
      S_CARRY: begin
        add_a      = t[3:0];
        add_b      = {3'b000, cin};
        state_next = last_nib ? S_DONE : S_ADD;
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Operand capture and partial-sum register; no reset needed, every use is
  // preceded by a write in the same operation.
  always_ff @(posedge CLK) begin
    if (!RESET && accept) begin
      a_r <= bus.A;
      b_r <= bus.B;
    end
    if (!RESET && (state == S_ADD)) begin
      t <= bus.ADD_SUM;
    end
  end

  // Result, nibble index, carry and status flags.
  // BUSY/DONE are registered from the current state, so they trail the state
  // register by one cycle: DONE rises the cycle after the DONE state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sum_nib <= '0;
      cout    <= 1'b0;
      idx     <= '0;
      cin     <= 1'b0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      busy_r <= (state == S_ADD) || (state == S_CARRY);
      done_r <= (state == S_DONE);
      unique case (state)
        S_IDLE: begin
          if (bus.START) begin
            idx     <= '0;
            cin     <= 1'b0;
            sum_nib <= '0;
            cout    <= 1'b0;
          end
        end
        S_ADD: begin
`ifdef CARRY_SKIP_EN
          if (!cin) begin
            sum_nib[idx] <= bus.ADD_SUM[3:0];
            cin          <= bus.ADD_SUM[4];
            if (last_nib) begin
              cout <= bus.ADD_SUM[4];
            end else begin
              idx <= idx + 1'b1;
            end
          end
`endif
        end
        S_CARRY: begin
          // t[4] and ADD_SUM[4] are mutually exclusive, so OR is the carry-out.
          sum_nib[idx] <= bus.ADD_SUM[3:0];
          cin          <= t[4] | bus.ADD_SUM[4];
          if (last_nib) begin
            cout <= t[4] | bus.ADD_SUM[4];
          end else begin
            idx <= idx + 1'b1;
          end
        end
        S_DONE: begin
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.BUSY  = busy_r;
  assign bus.DONE  = done_r;
  assign bus.SUM   = {cout, sum_nib};
  assign bus.ADD_A = add_a;
  assign bus.ADD_B = add_b;

endmodule
